// File: rtl/tone_synth.sv
// tone_synth: priority-keyed square-wave note generator with octave shift and sub-octave output.
// Define TONE_SYNTH_RELEASE_EN to build the release tail (RELEASE state plus hold timer).
module tone_synth #(
  parameter int CLK_HZ   = 25000000,
  parameter int DIV_W    = 16,
  parameter int NUM_KEYS = 7,
  parameter int HOLD_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key,
  input  logic [1:0]          octave,
  output logic                audio_l,
  output logic                audio_r,
  output logic                active,
  output logic [2:0]          note_idx
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
`ifdef TONE_SYNTH_RELEASE_EN
  localparam logic [1:0] RELEASE = 2'd2;
  localparam int HW = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;
  logic [HW-1:0] hold_d, hold_q;
`endif
  if (HOLD_CYC < 1) begin : g_hold_chk
    $error("HOLD_CYC must be at least 1");
  end
  function automatic int half_period(input logic [2:0] k);
    int f;
    f = k == 3'd0 ? 440 : k == 3'd1 ? 494 : k == 3'd2 ? 523 : k == 3'd3 ? 587 :
        k == 3'd4 ? 659 : k == 3'd5 ? 698 : 784;
    return CLK_HZ / (2 * f);
  endfunction
  logic [NUM_KEYS-1:0] key_q;
  logic [1:0]          state_d, state_q;
  logic [DIV_W-1:0]    cnt_d, cnt_q, h;
  logic [2:0]          win, sel, note_d, note_q;
  logic                aud_l_d, aud_l_q, aud_r_d, aud_r_q, pressed, wrap;
  int                  hs;
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_KEYS; i++) if (key_q[i]) win = 3'(i);
    pressed = |key_q;
    // In RELEASE no key is held, so reloads keep the last latched note
    sel = pressed ? win : note_q;
    hs = half_period(sel) >> octave;
    h = hs < 1 ? DIV_W'(1) : DIV_W'(hs);
    wrap = cnt_q == '0;
    state_d = state_q;
    cnt_d = cnt_q;
    note_d = note_q;
    aud_l_d = aud_l_q;
    aud_r_d = aud_r_q;
`ifdef TONE_SYNTH_RELEASE_EN
    hold_d = hold_q;
`endif
    if (state_q == IDLE) begin
      if (pressed) begin
        state_d = PLAY;
        cnt_d = h - DIV_W'(1);
        note_d = win;
      end
    end else begin
      cnt_d = wrap ? h - DIV_W'(1) : cnt_q - DIV_W'(1);
      note_d = wrap ? sel : note_q;
      aud_l_d = wrap ? ~aud_l_q : aud_l_q;
      aud_r_d = aud_r_q ^ (aud_l_d & ~aud_l_q);
`ifdef TONE_SYNTH_RELEASE_EN
      if (pressed) state_d = PLAY;
      else if (state_q == PLAY) begin
        state_d = RELEASE;
        hold_d = HW'(HOLD_CYC - 1);
      end else if (hold_q == '0) begin
        state_d = IDLE;
        cnt_d = '0;
        aud_l_d = 1'b0;
        aud_r_d = 1'b0;
      end else hold_d = hold_q - HW'(1);
`else
      if (!pressed) begin
        state_d = IDLE;
        cnt_d = '0;
        aud_l_d = 1'b0;
        aud_r_d = 1'b0;
      end
`endif
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= '0;
      state_q <= IDLE;
      cnt_q <= '0;
      note_q <= '0;
      aud_l_q <= 1'b0;
      aud_r_q <= 1'b0;
`ifdef TONE_SYNTH_RELEASE_EN
      hold_q <= '0;
`endif
    end else begin
      key_q <= key;
      state_q <= state_d;
      cnt_q <= cnt_d;
      note_q <= note_d;
      aud_l_q <= aud_l_d;
      aud_r_q <= aud_r_d;
`ifdef TONE_SYNTH_RELEASE_EN
      hold_q <= hold_d;
`endif
    end
  end
  assign audio_l = aud_l_q;
  assign audio_r = aud_r_q;
  assign active = state_q != IDLE;
  assign note_idx = note_q;
endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: table-driven tone checks plus key-switch and release sequences, scoreboard compared.
module tb_tone_synth;
  logic       clk = 1'b0, rst = 1'b1;
  logic [6:0] key = '0;
  logic [1:0] octave = '0;
  logic       audio_l, audio_r, active;
  logic [2:0] note_idx;
  int         n_cmp = 0, n_bad = 0, cyc = 0;
  typedef struct { logic l, r, act; logic [2:0] idx; } obs_t;
  typedef struct { logic [6:0] k; logic [1:0] o; int h; logic [2:0] i; } vec_t;
  obs_t sb[$];
  vec_t vt[11];
  always #5 clk = ~clk;
  tone_synth #(.CLK_HZ(8800), .DIV_W(8), .NUM_KEYS(7), .HOLD_CYC(40)) dut (
    .clk(clk), .rst(rst), .key(key), .octave(octave),
    .audio_l(audio_l), .audio_r(audio_r), .active(active), .note_idx(note_idx)
  );
  task automatic chk(string name, int got, int exp_v);
    n_cmp++;
    if (got != exp_v) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, got, exp_v);
    end
  endtask
  // n = number of audio_l toggles since PLAY entry; audio_r counts rises of audio_l
  function automatic obs_t mk(int n, logic a, logic [2:0] idx);
    obs_t e;
    e.act = a;
    e.idx = idx;
    e.l = a ? logic'(n % 2) : 1'b0;
    e.r = a ? logic'(((n + 1) / 2) % 2) : 1'b0;
    return e;
  endfunction
  always @(posedge clk) begin
    obs_t e;
    cyc++;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("audio_l", audio_l, e.l);
      chk("audio_r", audio_r, e.r);
      chk("active", active, e.act);
      chk("note_idx", note_idx, e.idx);
    end
  end
  task automatic drive(logic [6:0] k, logic [1:0] o, obs_t e);
    @(negedge clk);
    key = k;
    octave = o;
    sb.push_back(e);
  endtask
  task automatic drain();
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_empty", sb.size(), 0);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #3;
    key = '0;
    rst = 1'b1;
    #1;
    chk("rst_audio_l", audio_l, 0);
    chk("rst_audio_r", audio_r, 0);
    chk("rst_active", active, 0);
    chk("rst_note_idx", note_idx, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic switch_seq(logic [6:0] k1, logic [1:0] o1, int h1, logic [2:0] i1,
                            logic [6:0] k2, logic [1:0] o2, int h2, logic [2:0] i2);
    do_reset();
    drive(k1, o1, mk(0, 1'b0, 3'd0));
    for (int j = 0; j < h1 + 3 * h2 + 4; j++) begin
      int n;
      n = j < h1 ? 0 : 1 + (j - h1) / h2;
      drive(j < 2 ? k1 : k2, j < 2 ? o1 : o2, mk(n, 1'b1, j < h1 ? i1 : i2));
    end
    drain();
  endtask
  // key_q drops at j=59, so the PLAY->leave edge (j=60) coincides with a reload
  task automatic rel_seq(int rp);
    do_reset();
    drive(7'b0000001, 2'd0, mk(0, 1'b0, 3'd0));
    for (int j = 0; j < 130; j++) begin
      obs_t e;
`ifdef TONE_SYNTH_RELEASE_EN
      e = (rp <= 99 || j < 100) ? mk(j / 10, 1'b1, 3'd0) : mk(0, 1'b0, 3'd0);
`else
      e = j < 60 ? mk(j / 10, 1'b1, 3'd0) : j <= rp ? mk(0, 1'b0, 3'd0) : mk((j - rp - 1) / 10, 1'b1, 3'd0);
`endif
      drive((j >= 59 && j < rp) ? 7'd0 : 7'b0000001, 2'd0, e);
    end
    drain();
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    vt[0]  = '{7'b0000001, 2'd0, 10, 3'd0};
    vt[1]  = '{7'b1000001, 2'd0, 5, 3'd6};
    vt[2]  = '{7'b0000001, 2'd1, 5, 3'd0};
    vt[3]  = '{7'b0000001, 2'd3, 1, 3'd0};
    vt[4]  = '{7'b0000110, 2'd0, 8, 3'd2};
    vt[5]  = '{7'b0011000, 2'd2, 1, 3'd4};
    vt[6]  = '{7'b0000010, 2'd1, 4, 3'd1};
    vt[7]  = '{7'b0101000, 2'd0, 6, 3'd5};
    vt[8]  = '{7'b0001000, 2'd0, 7, 3'd3};
    vt[9]  = '{7'b1000000, 2'd2, 1, 3'd6};
    vt[10] = '{7'b0000001, 2'd2, 2, 3'd0};
    do_reset();
    for (int j = 0; j < 6; j++) drive(7'd0, 2'd0, mk(0, 1'b0, 3'd0));
    drain();
    for (int v = 0; v < 11; v++) begin
      do_reset();
      drive(vt[v].k, vt[v].o, mk(0, 1'b0, 3'd0));
      for (int j = 0; j < 4 * vt[v].h + 8; j++)
        drive(vt[v].k, vt[v].o, mk(j / vt[v].h, 1'b1, vt[v].i));
      drain();
    end
    switch_seq(7'b1000001, 2'd0, 5, 3'd6, 7'b0000001, 2'd0, 10, 3'd0);
    switch_seq(7'b0000001, 2'd1, 5, 3'd0, 7'b0000001, 2'd3, 1, 3'd0);
    switch_seq(7'b0000001, 2'd0, 10, 3'd0, 7'b1000000, 2'd1, 2, 3'd6);
    rel_seq(1000);
    rel_seq(80);
    rel_seq(99);
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tone_synth.md
# tone_synth

Parametrised successor to the single-tone square-wave beeper. It is a priority-keyed note generator with a compile-time-sized pitch table, a runtime octave shift, and phase-continuous note changes. It also has an optional release tail and a sub-octave second output. It sits between the raw key/switch inputs of the user module and the audio output pins.

## Interface
- `CLK_HZ`, 25000000: input clock frequency; all pitch periods derive from it.
- `DIV_W`, 16: period counter width; must hold `CLK_HZ/880` (A4 half-period).
- `NUM_KEYS`, 7: number of key inputs, 1..7; key k selects note k of A4,B4,C5,D5,E5,F5,G5.
- `HOLD_CYC`, 1000000: release-tail length in clk cycles (used only with the release feature).
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `key` input `NUM_KEYS`: key levels, sampled once per clk into `key_q`.
- `octave` input 2: octave up-shift 0..3 applied to the selected note.
- `audio_l` output 1: main square wave.
- `audio_r` output 1: sub-octave square wave (half the frequency of `audio_l`).
- `active` output 1: high while a note is sounding (PLAY or RELEASE).
- `note_idx` output 3: index of the currently latched note.

## Operation
- Pitch table: `F` = 440, 494, 523, 587, 659, 698, 784 Hz.
  - Half-period `H_k = CLK_HZ/(2*F_k)`, truncated.
  - Effective `H = max(1, H_k >> octave)`.
- Priority: the highest set index in `key_q` wins.
- FSM states: IDLE, PLAY, RELEASE.
- IDLE:
  - Counter = 0; `audio_l`/`audio_r` held 0; `active` = 0.
  - If `key_q` is nonzero: latch note, load counter with H-1, go to PLAY.
- PLAY:
  - Counter decrements each cycle.
  - At counter==0: toggle `audio_l` and reload with H-1 of the current winning note and current `octave`. `note_idx` updates at the same reload.
  - A key or octave change mid-period takes effect only at the next reload. This keeps the phase continuous, with no glitch or truncated half-cycle.
  - If `key_q` becomes 0: go to RELEASE (or to IDLE without the feature) and load the hold timer with `HOLD_CYC`-1.
- RELEASE:
  - The tone continues with the last latched note; the hold timer decrements each cycle.
  - Any key pressed: return to PLAY without a phase reset.
  - Timer reaches 0: go to IDLE; outputs forced 0 on that same edge.
- `audio_r` toggles on every rising transition of `audio_l`; it is forced 0 in IDLE.
- Simultaneous events:
  - Reload and key release on the same cycle: the toggle happens, then the state changes.
  - Hold-timer expiry and a key press on the same cycle: the key wins and the state stays PLAY.
- Reset at any time: all state and outputs go to reset values immediately.

## Timing
- Reset values:
  - `audio_l`=0, `audio_r`=0, `active`=0, `note_idx`=0.
  - Counter, hold timer and `key_q` = 0; state IDLE.
- Key asserted before edge N: `key_q` set at N; PLAY entered and counter = H-1 at N+1; `active`=1 at N+1.
- First `audio_l` rise at edge N+1+H; thereafter it toggles every H cycles, giving `CLK_HZ/(2H)` Hz.
- `audio_r` period is 4H cycles.
- Key released before edge M: `key_q`=0 at M; RELEASE entered at M+1; IDLE at M+1+`HOLD_CYC`, with `active`=0 and outputs 0 on that edge.

## Configuration
- `TONE_SYNTH_RELEASE_EN` defined:
  - RELEASE state and hold timer present, as above.
- Not defined:
  - PLAY goes directly to IDLE one cycle after `key_q` becomes 0.
  - No hold-timer logic is built, and `HOLD_CYC` is ignored.

## Test plan
All scenarios use `CLK_HZ`=8800, `DIV_W`=8, `HOLD_CYC`=40, macro defined unless stated.
- Reset mid-tone: assert `rst` async → all outputs 0 the same cycle; deassert, no key → outputs stay 0, `active`=0.
- `key`=0000001, `octave`=0 → `audio_l` toggles every 10 cycles (H=10), first rise 11 cycles after `key_q`; `audio_r` period 40; `note_idx`=0.
- `key`=1000001 → G5 wins, toggle every 5 cycles, `note_idx`=6. Switch mid-period to `key`=0000001 → current half-period completes at 5, next half-period 10.
- `key`=0000001, `octave`=1 → H=5. Set `octave`=3 → H=max(1,10>>3)=1, toggles every cycle.
- Release after 3 full periods → tone continues 40 cycles, then `active`=0 and `audio_l`=`audio_r`=0. Re-press at cycle 20 of the tail → stays PLAY, no phase jump.
- Macro undefined, same release → IDLE and outputs 0 exactly 1 cycle after `key_q`=0.
